// File: rtl/frontend_command_definition_pkg.sv
// Command definitions shared by the interconnection, the frontend scheduler
// and the DRAM backend controller.
//   op_type_t          : read / write
//   core_num_t         : originating core
//   req_id_t           : per-request identifier returned with read data
//   frontend_command_t : packed command {op_type, core_num, req_id, address}
package frontend_command_definition_pkg;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_type_t;

  typedef logic [1:0]  core_num_t;
  typedef logic [3:0]  req_id_t;
  typedef logic [31:0] address_t;

  typedef struct packed {
    op_type_t  op_type;
    core_num_t core_num;
    req_id_t   req_id;
    address_t  address;
  } frontend_command_t;

endpackage

// File: rtl/dram_frontend_scheduler.sv
// DRAM frontend scheduler.
// Write path: a command plus four frontend beats are packed into one backend
// word and issued as a single backend command. Read path: the read command is
// forwarded, its {req_id, core_num} tag queued, and each returned backend word
// is split into four frontend beats tagged with the oldest outstanding read.
// Reads complete strictly in order.
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   o_scheduler_ready                 command accept (interconnection side)
//   i_interconnection_request_valid   command valid
//   i_interconnection_request         command
//   i_interconnection_write_data      write beat
//   i_interconnection_write_data_last final write beat marker (informational)
//   i_backend_controller_ready        backend accepts command
//   o_frontend_command_valid/_command command to backend
//   o_frontend_write_data             packed write word (beat 0 in LSBs)
//   o_stall_backend_controller        tag FIFO full
//   o_frontend_receive_ready          ready for returned data
//   i_returned_data_valid/_data       returned backend word
//   i_interconnection_ready           interconnection accepts a read beat
//   o_scheduler_request_valid         read beat valid
//   o_scheduler_read_data/_last       read beat, final beat marker
//   o_scheduler_request_id/_core_num  tag of the read being returned
module dram_frontend_scheduler
  import frontend_command_definition_pkg::*;
#(
  parameter int unsigned FRONTEND_WORD_SIZE = 256,
  parameter int unsigned BACKEND_WORD_SIZE  = 1024,  // must be 4*FRONTEND_WORD_SIZE
  parameter int unsigned READ_TAG_DEPTH     = 4      // power of 2, >= 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  output logic                          o_scheduler_ready,
  input  logic                          i_interconnection_request_valid,
  input  frontend_command_t             i_interconnection_request,
  input  logic [FRONTEND_WORD_SIZE-1:0] i_interconnection_write_data,
  input  logic                          i_interconnection_write_data_last,
  input  logic                          i_backend_controller_ready,
  output logic                          o_frontend_command_valid,
  output frontend_command_t             o_frontend_command,
  output logic [BACKEND_WORD_SIZE-1:0]  o_frontend_write_data,
  output logic                          o_stall_backend_controller,
  output logic                          o_frontend_receive_ready,
  input  logic                          i_returned_data_valid,
  input  logic [BACKEND_WORD_SIZE-1:0]  i_returned_data,
  input  logic                          i_interconnection_ready,
  output logic                          o_scheduler_request_valid,
  output logic [FRONTEND_WORD_SIZE-1:0] o_scheduler_read_data,
  output logic                          o_scheduler_read_data_last,
  output req_id_t                       o_scheduler_request_id,
  output core_num_t                     o_scheduler_core_num
);

  localparam int unsigned BEATS     = BACKEND_WORD_SIZE / FRONTEND_WORD_SIZE;
  localparam int unsigned BEAT_W    = $clog2(BEATS);
  localparam int unsigned TAG_PTR_W = $clog2(READ_TAG_DEPTH);
  localparam int unsigned TAG_CNT_W = $clog2(READ_TAG_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} req_state_t;
  typedef enum logic {R_IDLE, R_SEND} ret_state_t;

  typedef struct packed {
    req_id_t   req_id;
    core_num_t core_num;
  } tag_t;

  req_state_t                                  req_state;
  ret_state_t                                  ret_state;
  logic [BEAT_W-1:0]                           wr_beat;
  logic [BEAT_W-1:0]                           rd_beat;
  logic [BEATS-1:0][FRONTEND_WORD_SIZE-1:0]    wr_pack;
  logic [BEATS-1:0][FRONTEND_WORD_SIZE-1:0]    ret_word;

  tag_t                                        tag_mem [READ_TAG_DEPTH];
  logic [TAG_PTR_W-1:0]                        tag_wr_ptr;
  logic [TAG_PTR_W-1:0]                        tag_rd_ptr;
  logic [TAG_CNT_W-1:0]                        tag_count;
  logic [TAG_CNT_W-1:0]                        tag_count_next;
  logic                                        tag_full;
  logic                                        tag_full_next;
  logic                                        tag_empty;
  logic                                        tag_push;
  logic                                        tag_pop;
  logic                                        req_hs;
  logic                                        unused_write_last;

  // Beat counting is positional; the last marker carries no extra information.
  assign unused_write_last = i_interconnection_write_data_last;

  assign o_frontend_write_data      = wr_pack;
  assign o_stall_backend_controller = tag_full;

  assign req_hs    = o_scheduler_ready && i_interconnection_request_valid;
  assign tag_push  = o_frontend_command_valid && i_backend_controller_ready &&
                     (o_frontend_command.op_type == OP_READ);
  assign tag_pop   = (ret_state == R_IDLE) && i_returned_data_valid && !tag_empty;
  assign tag_full  = (tag_count == TAG_CNT_W'(READ_TAG_DEPTH));
  assign tag_empty = (tag_count == '0);

  always_comb begin
    tag_count_next = tag_count;
    if (tag_push && !tag_pop) begin
      tag_count_next = tag_count + TAG_CNT_W'(1);
    end else if (!tag_push && tag_pop) begin
      tag_count_next = tag_count - TAG_CNT_W'(1);
    end
  end

  // o_scheduler_ready is registered, so it is computed from the FIFO count
  // the next cycle will see.
  assign tag_full_next = (tag_count_next == TAG_CNT_W'(READ_TAG_DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_count  <= '0;
      for (int unsigned i = 0; i < READ_TAG_DEPTH; i++) begin
        tag_mem[i] <= '0;
      end
    end else begin
      tag_count <= tag_count_next;
      if (tag_push) begin
        tag_mem[tag_wr_ptr] <= '{req_id: o_frontend_command.req_id,
                                 core_num: o_frontend_command.core_num};
        tag_wr_ptr          <= tag_wr_ptr + TAG_PTR_W'(1);
      end
      if (tag_pop) begin
        tag_rd_ptr <= tag_rd_ptr + TAG_PTR_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_state                <= IDLE;
      o_scheduler_ready        <= 1'b1;
      o_frontend_command_valid <= 1'b0;
      o_frontend_command       <= '0;
      wr_pack                  <= '0;
      wr_beat                  <= '0;
    end else begin
      case (req_state)
        IDLE: begin
          if (req_hs) begin
            o_frontend_command <= i_interconnection_request;
            o_scheduler_ready  <= 1'b0;
            if (i_interconnection_request.op_type == OP_WRITE) begin
              wr_pack[0] <= i_interconnection_write_data;
              wr_beat    <= BEAT_W'(1);
              req_state  <= COLLECT;
            end else begin
              o_frontend_command_valid <= 1'b1;
              req_state                <= ISSUE;
            end
          end else begin
            o_scheduler_ready <= !tag_full_next;
          end
        end
        COLLECT: begin
          wr_pack[wr_beat] <= i_interconnection_write_data;
          wr_beat          <= wr_beat + BEAT_W'(1);
          if (wr_beat == BEAT_W'(BEATS - 1)) begin
            o_frontend_command_valid <= 1'b1;
            req_state                <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_backend_controller_ready) begin
            o_frontend_command_valid <= 1'b0;
            o_scheduler_ready        <= !tag_full_next;
            req_state                <= IDLE;
          end
        end
        default: req_state <= IDLE;
      endcase
    end
  end

  // Beat 0 is presented straight from the incoming word; later beats come
  // from the latched copy so the outputs stay registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ret_state                  <= R_IDLE;
      o_frontend_receive_ready   <= 1'b1;
      o_scheduler_request_valid  <= 1'b0;
      o_scheduler_read_data      <= '0;
      o_scheduler_read_data_last <= 1'b0;
      o_scheduler_request_id     <= '0;
      o_scheduler_core_num       <= '0;
      ret_word                   <= '0;
      rd_beat                    <= '0;
    end else begin
      case (ret_state)
        R_IDLE: begin
          if (i_returned_data_valid) begin
            ret_word <= i_returned_data;
            if (!tag_empty) begin
              o_scheduler_request_id     <= tag_mem[tag_rd_ptr].req_id;
              o_scheduler_core_num       <= tag_mem[tag_rd_ptr].core_num;
              o_scheduler_read_data      <= i_returned_data[FRONTEND_WORD_SIZE-1:0];
              o_scheduler_read_data_last <= 1'b0;
              o_scheduler_request_valid  <= 1'b1;
              o_frontend_receive_ready   <= 1'b0;
              rd_beat                    <= '0;
              ret_state                  <= R_SEND;
            end
          end
        end
        R_SEND: begin
          if (i_interconnection_ready) begin
            if (rd_beat == BEAT_W'(BEATS - 1)) begin
              o_scheduler_request_valid  <= 1'b0;
              o_scheduler_read_data_last <= 1'b0;
              o_frontend_receive_ready   <= 1'b1;
              ret_state                  <= R_IDLE;
            end else begin
              rd_beat                    <= rd_beat + BEAT_W'(1);
              o_scheduler_read_data      <= ret_word[rd_beat + BEAT_W'(1)];
              o_scheduler_read_data_last <= (rd_beat == BEAT_W'(BEATS - 2));
            end
          end
        end
        default: ret_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_frontend_scheduler.sv
// Directed bench for dram_frontend_scheduler with scoreboard queues for
// issued commands, outstanding read tags and returned read beats.
module tb_dram_frontend_scheduler;
  import frontend_command_definition_pkg::*;

  localparam int unsigned FW    = 256;
  localparam int unsigned BW    = 1024;
  localparam int unsigned DEPTH = 4;

  logic              i_clk;
  logic              i_rst_n;
  logic              o_scheduler_ready;
  logic              i_interconnection_request_valid;
  frontend_command_t i_interconnection_request;
  logic [FW-1:0]     i_interconnection_write_data;
  logic              i_interconnection_write_data_last;
  logic              i_backend_controller_ready;
  logic              o_frontend_command_valid;
  frontend_command_t o_frontend_command;
  logic [BW-1:0]     o_frontend_write_data;
  logic              o_stall_backend_controller;
  logic              o_frontend_receive_ready;
  logic              i_returned_data_valid;
  logic [BW-1:0]     i_returned_data;
  logic              i_interconnection_ready;
  logic              o_scheduler_request_valid;
  logic [FW-1:0]     o_scheduler_read_data;
  logic              o_scheduler_read_data_last;
  req_id_t           o_scheduler_request_id;
  core_num_t         o_scheduler_core_num;

  logic [3:0][FW-1:0] wd_view;
  assign wd_view = o_frontend_write_data;

  dram_frontend_scheduler #(
    .FRONTEND_WORD_SIZE(FW),
    .BACKEND_WORD_SIZE (BW),
    .READ_TAG_DEPTH    (DEPTH)
  ) dut (
    .i_clk                            (i_clk),
    .i_rst_n                          (i_rst_n),
    .o_scheduler_ready                (o_scheduler_ready),
    .i_interconnection_request_valid  (i_interconnection_request_valid),
    .i_interconnection_request        (i_interconnection_request),
    .i_interconnection_write_data     (i_interconnection_write_data),
    .i_interconnection_write_data_last(i_interconnection_write_data_last),
    .i_backend_controller_ready       (i_backend_controller_ready),
    .o_frontend_command_valid         (o_frontend_command_valid),
    .o_frontend_command               (o_frontend_command),
    .o_frontend_write_data            (o_frontend_write_data),
    .o_stall_backend_controller       (o_stall_backend_controller),
    .o_frontend_receive_ready         (o_frontend_receive_ready),
    .i_returned_data_valid            (i_returned_data_valid),
    .i_returned_data                  (i_returned_data),
    .i_interconnection_ready          (i_interconnection_ready),
    .o_scheduler_request_valid        (o_scheduler_request_valid),
    .o_scheduler_read_data            (o_scheduler_read_data),
    .o_scheduler_read_data_last       (o_scheduler_read_data_last),
    .o_scheduler_request_id           (o_scheduler_request_id),
    .o_scheduler_core_num             (o_scheduler_core_num)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    frontend_command_t  cmd;
    logic [3:0][FW-1:0] data;
  } cmd_exp_t;

  typedef struct {
    logic [FW-1:0] data;
    req_id_t       id;
    core_num_t     core;
    logic          last;
  } beat_exp_t;

  typedef struct {
    req_id_t   id;
    core_num_t core;
  } tag_exp_t;

  cmd_exp_t  cmd_q  [$];
  beat_exp_t beat_q [$];
  tag_exp_t  tag_q  [$];

  int unsigned n_compared   = 0;
  int unsigned n_mismatched = 0;

  task automatic chk(input string name, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [FW-1:0] rand_beat();
    logic [FW-1:0] r;
    for (int unsigned i = 0; i < FW / 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic wait_sched_ready();
    for (int i = 0; i < 20 && !o_scheduler_ready; i++) tick();
    chk("sched_ready_wait", o_scheduler_ready, 1'b1);
  endtask

  task automatic check_cmd_out(input string name, input cmd_exp_t e, input bit is_write);
    chk({name, "_valid"}, o_frontend_command_valid, 1'b1);
    chk({name, "_cmd"}, o_frontend_command, e.cmd);
    if (is_write) begin
      for (int unsigned k = 0; k < 4; k++) begin
        chk($sformatf("%s_data%0d", name, k), wd_view[2'(k)], e.data[2'(k)]);
      end
    end
  endtask

  // Command is expected valid now; backend ready is held low for 'hold' more edges.
  task automatic issue_and_accept(input string name, input int unsigned hold);
    cmd_exp_t e;
    tag_exp_t t;
    bit       is_write;
    e        = cmd_q.pop_front();
    is_write = (e.cmd.op_type == OP_WRITE);
    check_cmd_out(name, e, is_write);
    for (int unsigned h = 0; h < hold; h++) begin
      tick();
      check_cmd_out($sformatf("%s_hold%0d", name, h), e, is_write);
    end
    i_backend_controller_ready = 1'b1;
    tick();
    chk({name, "_released"}, o_frontend_command_valid, 1'b0);
    if (!is_write) begin
      t.id   = e.cmd.req_id;
      t.core = e.cmd.core_num;
      tag_q.push_back(t);
    end
  endtask

  task automatic do_write(input frontend_command_t c, input logic [3:0][FW-1:0] beats,
                          input int unsigned hold);
    cmd_exp_t e;
    wait_sched_ready();
    if (hold > 0) i_backend_controller_ready = 1'b0;
    e.cmd  = c;
    e.data = beats;
    cmd_q.push_back(e);
    i_interconnection_request_valid   = 1'b1;
    i_interconnection_request         = c;
    i_interconnection_write_data      = beats[0];
    i_interconnection_write_data_last = 1'b0;
    tick();
    i_interconnection_request_valid = 1'b0;
    for (int unsigned k = 1; k < 4; k++) begin
      chk($sformatf("wr_latency_e%0d", k), o_frontend_command_valid, 1'b0);
      i_interconnection_write_data      = beats[2'(k)];
      i_interconnection_write_data_last = (k == 3);
      tick();
    end
    i_interconnection_write_data_last = 1'b0;
    i_interconnection_write_data      = '0;
    issue_and_accept("write", hold);
  endtask

  task automatic do_read(input req_id_t id, input core_num_t core, input address_t addr,
                         input int unsigned hold);
    cmd_exp_t e;
    wait_sched_ready();
    if (hold > 0) i_backend_controller_ready = 1'b0;
    e.cmd  = '{op_type: OP_READ, core_num: core, req_id: id, address: addr};
    e.data = '0;
    cmd_q.push_back(e);
    i_interconnection_request_valid = 1'b1;
    i_interconnection_request       = e.cmd;
    tick();
    i_interconnection_request_valid = 1'b0;
    issue_and_accept("read", hold);
  endtask

  task automatic return_word(input logic [3:0][FW-1:0] w);
    tag_exp_t  t;
    beat_exp_t b;
    for (int i = 0; i < 40 && !o_frontend_receive_ready; i++) tick();
    chk("recv_ready_wait", o_frontend_receive_ready, 1'b1);
    if (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      for (int unsigned k = 0; k < 4; k++) begin
        b.data = w[2'(k)];
        b.id   = t.id;
        b.core = t.core;
        b.last = (k == 3);
        beat_q.push_back(b);
      end
    end
    i_returned_data_valid = 1'b1;
    i_returned_data       = w;
    tick();
    i_returned_data_valid = 1'b0;
    i_returned_data       = '0;
  endtask

  // Drains expected beats; interconnection ready follows 'pattern' cycle by cycle.
  task automatic collect(input string name, input logic [7:0] pattern);
    int unsigned cyc;
    beat_exp_t   e;
    cyc = 0;
    while (beat_q.size() > 0 && cyc < 60) begin
      i_interconnection_ready = pattern[cyc[2:0]];
      if (o_scheduler_request_valid) begin
        e = beat_q[0];
        chk({name, "_data"}, o_scheduler_read_data, e.data);
        chk({name, "_id"},   o_scheduler_request_id, e.id);
        chk({name, "_core"}, o_scheduler_core_num, e.core);
        chk({name, "_last"}, o_scheduler_read_data_last, e.last);
        if (i_interconnection_ready) void'(beat_q.pop_front());
      end
      tick();
      cyc++;
    end
    i_interconnection_ready = 1'b0;
    chk({name, "_drained"}, (beat_q.size() == 0), 1'b1);
    chk({name, "_idle_valid"}, o_scheduler_request_valid, 1'b0);
    chk({name, "_recv_ready"}, o_frontend_receive_ready, 1'b1);
  endtask

  function automatic logic [3:0][FW-1:0] rand_word();
    logic [3:0][FW-1:0] w;
    for (int unsigned k = 0; k < 4; k++) w[2'(k)] = rand_beat();
    return w;
  endfunction

  initial begin
    logic [3:0][FW-1:0] beats;
    logic [3:0][FW-1:0] word;

    i_rst_n                           = 1'b0;
    i_interconnection_request_valid   = 1'b0;
    i_interconnection_request         = '0;
    i_interconnection_write_data      = '0;
    i_interconnection_write_data_last = 1'b0;
    i_backend_controller_ready        = 1'b1;
    i_returned_data_valid             = 1'b0;
    i_returned_data                   = '0;
    i_interconnection_ready           = 1'b0;
    repeat (3) tick();
    i_rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_sched_ready", o_scheduler_ready, 1'b1);
    chk("rst_recv_ready",  o_frontend_receive_ready, 1'b1);
    chk("rst_cmd_valid",   o_frontend_command_valid, 1'b0);
    chk("rst_req_valid",   o_scheduler_request_valid, 1'b0);
    chk("rst_stall",       o_stall_backend_controller, 1'b0);
    chk("rst_last",        o_scheduler_read_data_last, 1'b0);
    chk("rst_cmd",         o_frontend_command, '0);
    chk("rst_wdata0",      wd_view[0], '0);
    chk("rst_rdata",       o_scheduler_read_data, '0);
    chk("rst_id",          o_scheduler_request_id, '0);
    chk("rst_core",        o_scheduler_core_num, '0);

    // Write with fill beats, backend ready
    beats[0] = {32{8'h11}};
    beats[1] = {32{8'h22}};
    beats[2] = {32{8'h33}};
    beats[3] = {32{8'h44}};
    do_write('{op_type: OP_WRITE, core_num: 2'd1, req_id: 4'd3, address: 32'h0000_1000}, beats, 0);

    // Read id 5 core 2, then its return with continuous ready
    do_read(4'd5, 2'd2, 32'h0000_2040, 0);
    word = rand_word();
    return_word(word);
    collect("rd5", 8'hFF);

    // Backend backpressure on a write and on a read
    do_write('{op_type: OP_WRITE, core_num: 2'd3, req_id: 4'd7, address: 32'hDEAD_BE00},
             rand_word(), 3);
    do_read(4'd9, 2'd3, 32'h0000_3000, 2);
    word = rand_word();
    return_word(word);
    collect("rd9_toggle", 8'b0110_1001);

    // Fill the tag FIFO
    for (int unsigned i = 0; i < DEPTH; i++) begin
      do_read(4'(i + 1), 2'(i), 32'(32'h100 * i), 0);
    end
    chk("full_stall", o_stall_backend_controller, 1'b1);
    chk("full_sched_ready", o_scheduler_ready, 1'b0);
    return_word(rand_word());
    chk("drain_stall", o_stall_backend_controller, 1'b0);
    chk("drain_sched_ready", o_scheduler_ready, 1'b1);
    collect("fifo_r0", 8'b1101_1011);
    for (int unsigned i = 1; i < DEPTH; i++) begin
      return_word(rand_word());
      collect($sformatf("fifo_r%0d", i), 8'hFF);
    end

    // Return with no outstanding read is dropped
    return_word(rand_word());
    for (int unsigned i = 0; i < 4; i++) begin
      chk("discard_valid", o_scheduler_request_valid, 1'b0);
      chk("discard_recv_ready", o_frontend_receive_ready, 1'b1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
